// File: rtl/sys_ctrl_pkg.sv
// Shared widths, command codes, operand addresses and FSM state encoding
// for the UART command controller.
package sys_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int ALU_W  = 16;
    localparam int FUN_W  = 4;

    localparam logic [DATA_W-1:0] CMD_WR      = 8'hAA;
    localparam logic [DATA_W-1:0] CMD_RD      = 8'hBB;
    localparam logic [DATA_W-1:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [DATA_W-1:0] CMD_ALU_NOP = 8'hDD;

    localparam logic [ADDR_W-1:0] REG_OP_A = 4'd0;
    localparam logic [ADDR_W-1:0] REG_OP_B = 4'd1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WR_ADDR   = 4'd1,
        ST_WR_DATA   = 4'd2,
        ST_RD_ADDR   = 4'd3,
        ST_RD_WAIT   = 4'd4,
        ST_OP_A      = 4'd5,
        ST_OP_B      = 4'd6,
        ST_ALU_FUN_S = 4'd7,
        ST_ALU_WAIT  = 4'd8,
        ST_TX_B0     = 4'd9,
        ST_TX_B1     = 4'd10
    } state_e;

    // First-byte decode; unknown bytes leave the controller idle.
    function automatic state_e decode_cmd(input logic [DATA_W-1:0] b);
        state_e s;
        case (b)
            CMD_WR:      s = ST_WR_ADDR;
            CMD_RD:      s = ST_RD_ADDR;
            CMD_ALU_OP:  s = ST_OP_A;
            CMD_ALU_NOP: s = ST_ALU_FUN_S;
            default:     s = ST_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sys_ctrl_tx_stage.sv
// Reply holding register: stores one or two bytes and pushes them to the
// TX FIFO one per cycle whenever the FIFO is not full, LSB first.
module sys_ctrl_tx_stage
    import sys_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              two_i,
    input  logic [DATA_W-1:0] byte0_i,
    input  logic [DATA_W-1:0] byte1_i,
    input  logic              fifo_full_i,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_vld_o,
    output logic              sent_o,
    output logic              done_o
);

    logic              active_q;
    logic              idx_q;
    logic              two_q;
    logic [DATA_W-1:0] byte0_q;
    logic [DATA_W-1:0] byte1_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_vld_q;

    // sent_o marks the edge that issues a byte; done_o marks the final one.
    assign sent_o    = active_q & ~fifo_full_i;
    assign done_o    = sent_o & (idx_q | ~two_q);
    assign tx_data_o = tx_data_q;
    assign tx_vld_o  = tx_vld_q;

    // Load reply bytes and sequence the FIFO pushes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q  <= 1'b0;
            idx_q     <= 1'b0;
            two_q     <= 1'b0;
            byte0_q   <= {DATA_W{1'b0}};
            byte1_q   <= {DATA_W{1'b0}};
            tx_data_q <= {DATA_W{1'b0}};
            tx_vld_q  <= 1'b0;
        end else begin
            tx_vld_q <= 1'b0;
            if (load_i) begin
                active_q <= 1'b1;
                idx_q    <= 1'b0;
                two_q    <= two_i;
                byte0_q  <= byte0_i;
                byte1_q  <= byte1_i;
            end else if (sent_o) begin
                tx_data_q <= idx_q ? byte1_q : byte0_q;
                tx_vld_q  <= 1'b1;
                idx_q     <= 1'b1;
                if (done_o) begin
                    active_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/sys_ctrl.sv
// Command controller: parses framed UART command bytes, drives register-file
// and ALU strobes, and hands reply bytes to the TX stage.
module sys_ctrl
    import sys_ctrl_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] RX_P_DATA,
    input  logic              RX_D_VLD,
    input  logic [DATA_W-1:0] RdData,
    input  logic              RdData_Valid,
    input  logic [ALU_W-1:0]  ALU_OUT,
    input  logic              ALU_OUT_VALID,
    input  logic              FIFO_FULL,
    output logic [ADDR_W-1:0] Address,
    output logic              WrEn,
    output logic              RdEn,
    output logic [DATA_W-1:0] WrData,
    output logic              ALU_EN,
    output logic [FUN_W-1:0]  ALU_FUN,
    output logic              CLK_EN,
    output logic [DATA_W-1:0] TX_P_DATA,
    output logic              TX_D_VLD
);

    state_e            state_q;
    logic              tx_load_s;
    logic              tx_two_s;
    logic [DATA_W-1:0] tx_b0_s;
    logic              tx_sent_s;
    logic              tx_done_s;

    // Reply capture happens on the same edge that moves the FSM into TX_B0.
    always_comb begin
        tx_load_s = 1'b0;
        tx_two_s  = 1'b0;
        tx_b0_s   = ALU_OUT[DATA_W-1:0];
        if (state_q == ST_RD_WAIT) begin
            tx_load_s = RdData_Valid;
            tx_b0_s   = RdData;
        end else if (state_q == ST_ALU_WAIT) begin
            tx_load_s = ALU_OUT_VALID;
            tx_two_s  = 1'b1;
        end else begin
            tx_load_s = 1'b0;
        end
    end

    sys_ctrl_tx_stage u_tx (
        .clk_i       (CLK),
        .rst_ni      (RST),
        .load_i      (tx_load_s),
        .two_i       (tx_two_s),
        .byte0_i     (tx_b0_s),
        .byte1_i     (ALU_OUT[ALU_W-1:DATA_W]),
        .fifo_full_i (FIFO_FULL),
        .tx_data_o   (TX_P_DATA),
        .tx_vld_o    (TX_D_VLD),
        .sent_o      (tx_sent_s),
        .done_o      (tx_done_s)
    );

    // Command FSM with registered register-file / ALU outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            Address <= {ADDR_W{1'b0}};
            WrEn    <= 1'b0;
            RdEn    <= 1'b0;
            WrData  <= {DATA_W{1'b0}};
            ALU_EN  <= 1'b0;
            ALU_FUN <= {FUN_W{1'b0}};
            CLK_EN  <= 1'b0;
        end else begin
            WrEn   <= 1'b0;
            RdEn   <= 1'b0;
            ALU_EN <= 1'b0;
            case (state_q)
                ST_IDLE: if (RX_D_VLD) state_q <= decode_cmd(RX_P_DATA);
                ST_WR_ADDR: if (RX_D_VLD) begin
                    Address <= RX_P_DATA[ADDR_W-1:0];
                    state_q <= ST_WR_DATA;
                end
                ST_WR_DATA: if (RX_D_VLD) begin
                    WrEn    <= 1'b1;
                    WrData  <= RX_P_DATA;
                    state_q <= ST_IDLE;
                end
                ST_RD_ADDR: if (RX_D_VLD) begin
                    RdEn    <= 1'b1;
                    Address <= RX_P_DATA[ADDR_W-1:0];
                    state_q <= ST_RD_WAIT;
                end
                ST_RD_WAIT: if (RdData_Valid) state_q <= ST_TX_B0;
                ST_OP_A: if (RX_D_VLD) begin
                    WrEn    <= 1'b1;
                    Address <= REG_OP_A;
                    WrData  <= RX_P_DATA;
                    state_q <= ST_OP_B;
                end
                ST_OP_B: if (RX_D_VLD) begin
                    WrEn    <= 1'b1;
                    Address <= REG_OP_B;
                    WrData  <= RX_P_DATA;
                    state_q <= ST_ALU_FUN_S;
                end
                ST_ALU_FUN_S: if (RX_D_VLD) begin
                    ALU_FUN <= RX_P_DATA[FUN_W-1:0];
                    ALU_EN  <= 1'b1;
                    CLK_EN  <= 1'b1;
                    state_q <= ST_ALU_WAIT;
                end
                ST_ALU_WAIT: if (ALU_OUT_VALID) begin
                    CLK_EN  <= 1'b0;
                    state_q <= ST_TX_B0;
                end
                ST_TX_B0: begin
                    if (tx_done_s)      state_q <= ST_IDLE;
                    else if (tx_sent_s) state_q <= ST_TX_B1;
                end
                ST_TX_B1: if (tx_done_s) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_ctrl.sv
// Scoreboard bench for sys_ctrl: stimulus queues expected strobes, a negedge
// monitor pops and compares whenever the DUT presents one.
module tb_sys_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_vld = 1'b0;
    logic [7:0]  rd_data = 8'h00;
    logic        rd_vld = 1'b0;
    logic [15:0] alu_out = 16'h0000;
    logic        alu_vld = 1'b0;
    logic        fifo_full = 1'b0;

    logic [3:0]  Address;
    logic        WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD;
    logic [7:0]  WrData, TX_P_DATA;
    logic [3:0]  ALU_FUN;

    int checks = 0;
    int failures = 0;

    logic [11:0] wr_exp[$];
    logic [3:0]  rd_exp[$];
    logic [3:0]  alu_exp[$];
    logic [7:0]  tx_exp[$];

    sys_ctrl dut (
        .CLK(clk), .RST(rst_n),
        .RX_P_DATA(rx_data), .RX_D_VLD(rx_vld),
        .RdData(rd_data), .RdData_Valid(rd_vld),
        .ALU_OUT(alu_out), .ALU_OUT_VALID(alu_vld),
        .FIFO_FULL(fifo_full),
        .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s: unexpected strobe at %0t", name, $time);
    endtask

    // Monitor: compares every DUT strobe against the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (WrEn) begin
                if (wr_exp.size() == 0) unexpected("wren");
                else chk("wren", {20'h0, Address, WrData}, {20'h0, wr_exp.pop_front()});
            end
            if (RdEn) begin
                if (rd_exp.size() == 0) unexpected("rden");
                else chk("rden_addr", {28'h0, Address}, {28'h0, rd_exp.pop_front()});
            end
            if (ALU_EN) begin
                if (alu_exp.size() == 0) unexpected("alu_en");
                else begin
                    chk("alu_fun", {28'h0, ALU_FUN}, {28'h0, alu_exp.pop_front()});
                    chk("clk_en_at_alu_en", {31'h0, CLK_EN}, 32'h1);
                end
            end
            if (TX_D_VLD) begin
                if (tx_exp.size() == 0) unexpected("tx_vld");
                else chk("tx_data", {24'h0, TX_P_DATA}, {24'h0, tx_exp.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_vld  = 1'b1;
        tick();
        rx_vld  = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && tx_exp.size() != 0; i++) tick();
        tick();
        chk(name, tx_exp.size(), 32'h0);
    endtask

    function automatic logic [31:0] outs();
        return {3'b000, Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD};
    endfunction

    initial begin
        #2;
        chk("reset_outputs", outs(), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Register write, no reply expected.
        wr_exp.push_back({4'h5, 8'h3C});
        send(8'hAA); send(8'h05); send(8'h3C);
        repeat (4) tick();
        chk("wr_done", wr_exp.size(), 32'h0);

        // Register read with a delayed RdData_Valid.
        rd_exp.push_back(4'h2);
        tx_exp.push_back(8'h7E);
        send(8'hBB); send(8'h02);
        repeat (2) tick();
        rd_data = 8'h7E; rd_vld = 1'b1;
        tick();
        rd_vld = 1'b0;
        drain("rd_reply");

        // ALU with operands; CLK_EN window and back-to-back reply bytes.
        wr_exp.push_back({4'h0, 8'h12});
        wr_exp.push_back({4'h1, 8'h34});
        alu_exp.push_back(4'h0);
        tx_exp.push_back(8'h46);
        tx_exp.push_back(8'h00);
        send(8'hCC); send(8'h12); send(8'h34); send(8'h00);
        chk("alu_en_pulse", {31'h0, ALU_EN}, 32'h1);
        repeat (2) tick();
        chk("clk_en_wait", {31'h0, CLK_EN}, 32'h1);
        alu_out = 16'h0046; alu_vld = 1'b1;
        chk("clk_en_valid_cycle", {31'h0, CLK_EN}, 32'h1);
        tick();
        alu_vld = 1'b0;
        chk("clk_en_fall", {31'h0, CLK_EN}, 32'h0);
        chk("tx_not_yet", {31'h0, TX_D_VLD}, 32'h0);
        tick();
        chk("tx_b0_vld", {31'h0, TX_D_VLD}, 32'h1);
        tick();
        chk("tx_b1_vld", {31'h0, TX_D_VLD}, 32'h1);
        drain("alu_reply");

        // ALU without operands while the TX FIFO is full.
        alu_exp.push_back(4'h3);
        tx_exp.push_back(8'h34);
        tx_exp.push_back(8'h12);
        send(8'hDD); send(8'h03);
        tick();
        alu_out = 16'h1234; alu_vld = 1'b1; fifo_full = 1'b1;
        tick();
        alu_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("tx_held_full", {31'h0, TX_D_VLD}, 32'h0);
        end
        fifo_full = 1'b0;
        tick();
        chk("tx_after_full", {31'h0, TX_D_VLD}, 32'h1);
        drain("nop_reply");

        // Unknown first byte is dropped.
        wr_exp.push_back({4'h1, 8'hFF});
        send(8'h55); send(8'hAA); send(8'h01); send(8'hFF);
        repeat (3) tick();
        chk("unknown_then_wr", wr_exp.size(), 32'h0);

        // Reset in the middle of an operand sequence.
        wr_exp.push_back({4'h0, 8'hAB});
        send(8'hCC); send(8'hAB);
        tick();
        rst_n = 1'b0;
        #2;
        chk("midop_reset_outputs", outs(), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        rd_exp.push_back(4'h0);
        tx_exp.push_back(8'h99);
        send(8'hBB); send(8'h00);
        tick();
        rd_data = 8'h99; rd_vld = 1'b1;
        tick();
        rd_vld = 1'b0;
        drain("post_reset_read");

        repeat (3) tick();
        chk("wr_queue_empty", wr_exp.size(), 32'h0);
        chk("rd_queue_empty", rd_exp.size(), 32'h0);
        chk("alu_queue_empty", alu_exp.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sys_ctrl.md
# sys_ctrl

Command controller between the UART receive path and the system datapath: parses framed command bytes from the UART RX deserializer, sequences register-file writes and reads and ALU operations, and queues reply bytes toward the UART TX FIFO. It is the only master of the register file and ALU enable, and it owns the ALU clock-gate enable.

## Interface
- DATA_W, 8, command/data byte width
- ADDR_W, 4, register-file address width
- ALU_W, 16, ALU result width
- FUN_W, 4, ALU function code width

Reset RST, asynchronous, active-low; clock CLK.
- CLK  in  1  system clock
- RST  in  1  asynchronous active-low reset
- RX_P_DATA  in  DATA_W  received byte, valid with RX_D_VLD
- RX_D_VLD  in  1  one-cycle strobe per received byte
- RdData  in  DATA_W  register-file read data
- RdData_Valid  in  1  one-cycle strobe qualifying RdData
- ALU_OUT  in  ALU_W  ALU result
- ALU_OUT_VALID  in  1  one-cycle strobe qualifying ALU_OUT
- FIFO_FULL  in  1  TX FIFO full; no push allowed while high
- Address  out  ADDR_W  register-file address
- WrEn / RdEn  out  1  one-cycle register-file write / read strobes
- WrData  out  DATA_W  register-file write data
- ALU_EN  out  1  one-cycle ALU start strobe
- ALU_FUN  out  FUN_W  ALU function, held until the result is captured
- CLK_EN  out  1  ALU clock-gate enable
- TX_P_DATA  out  DATA_W  reply byte
- TX_D_VLD  out  1  one-cycle TX FIFO push

## Operation
- Commands (first byte): 0xAA write {addr, data}; 0xBB read {addr}, 1-byte reply; 0xCC ALU with operands {A, B, fun}, 2-byte reply; 0xDD ALU without operands {fun}, 2-byte reply. Any other first byte is dropped; the block stays in IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN_S, ALU_WAIT, TX_B0, TX_B1.
- **IDLE:** on RX_D_VLD, decode the byte and branch: 0xAA→WR_ADDR, 0xBB→RD_ADDR, 0xCC→OP_A, 0xDD→ALU_FUN_S.
- **WR_ADDR:** latch addr[ADDR_W-1:0], then go to WR_DATA.
- **WR_DATA:** on the byte, pulse WrEn with the latched Address and WrData = byte, then go to IDLE.
- **RD_ADDR:** on the byte, pulse RdEn with Address = byte, then go to RD_WAIT.
- **RD_WAIT:** on RdData_Valid, capture RdData into reply byte 0 and go to TX_B0 (single-byte reply).
- **OP_A / OP_B:** pulse WrEn to address 0 / 1 with the byte, then advance to OP_B / ALU_FUN_S.
- **ALU_FUN_S:** on the byte, set ALU_FUN = byte[FUN_W-1:0], pulse ALU_EN and assert CLK_EN, then go to ALU_WAIT.
- **ALU_WAIT:** on ALU_OUT_VALID, capture result[7:0] as byte 0 and result[15:8] as byte 1, deassert CLK_EN and go to TX_B0.
- **TX_B0 / TX_B1:** push one byte per state when FIFO_FULL=0. TX_B0 goes to TX_B1 for ALU replies and to IDLE for read replies; TX_B1 goes to IDLE.
- RX_D_VLD in RD_WAIT, ALU_WAIT, TX_B0 or TX_B1 is ignored and the byte is lost.
- There is no timeout: a missing RdData_Valid or ALU_OUT_VALID holds the FSM in the wait state until reset.

## Timing
- All outputs are registered.
- Reset values are all 0: Address, WrData, ALU_FUN, TX_P_DATA, all strobes and CLK_EN. State resets to IDLE.
- WrEn, RdEn and ALU_EN assert in the cycle after the qualifying RX_D_VLD and last exactly 1 cycle.
- Address and WrData are valid in the WrEn/RdEn cycle and held afterwards.
- CLK_EN:
  - rises in the ALU_EN cycle and stays high through the cycle that samples ALU_OUT_VALID;
  - falls one cycle later.
- TX_D_VLD asserts one cycle after entry to a TX state if FIFO_FULL=0; otherwise in the cycle after FIFO_FULL is sampled low.
  - Back-to-back pushes are allowed (byte 0 then byte 1 on consecutive cycles).
  - If FIFO_FULL rises between the two bytes, byte 1 waits.
- Reset mid-operation: all state and outputs clear immediately; a partial command is discarded and the next byte is decoded as a new command.

## Structure
- Package sys_ctrl_pkg holds:
  - command codes CMD_WR=8'hAA, CMD_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD;
  - operand addresses REG_OP_A=0, REG_OP_B=1;
  - the state encoding (4-bit, IDLE=0).
- Sub-module sys_ctrl_tx_stage: 2-byte reply holding register with FIFO_FULL-gated push sequencing and count 1 or 2. The FSM loads it and waits for its done strobe.

## Test plan
- AA,05,3C → one WrEn cycle with Address=5, WrData=0x3C; no TX_D_VLD.
- BB,02, then RdData=0x7E with RdData_Valid 3 cycles later → RdEn with Address=2, then TX_D_VLD with TX_P_DATA=0x7E, return to IDLE.
- CC,12,34,00, ALU_OUT=0x0046 valid → WrEn addr0=0x12, WrEn addr1=0x34, ALU_EN with ALU_FUN=0, CLK_EN high until valid, then TX pushes 0x46 then 0x00 on consecutive cycles.
- DD,03 with FIFO_FULL high for 5 cycles after the result → TX_D_VLD held low while full, both bytes pushed afterwards in order LSB, MSB.
- Unknown byte 0x55, then AA,01,FF → 0x55 ignored, write to address 1 occurs.
- RST low during OP_B → all outputs 0; after release, BB,00 is decoded as a read command.
